mult_div_seq: RTL and testbench
===============================

// Module: mult_div_seq
// PURPOSE
//  Multicycle sequencer + iterative datapath for signed MULT/DIV (HI/LO pair).
//  Driven by the main control unit: uc asserts start with the operation and
//  waits on done; rs/rt come from the A/B registers. Results sit in HI/LO until
//  the next completed operation (read via mfhi/mflo path).
// PARAMETERS
//  DATA_W   32  operand/result width; iteration count equals DATA_W
//  CNT_W    6   iteration counter width; must satisfy 2^CNT_W > DATA_W
// PORTS
//  clock    in   1       system clock, all state updates on posedge
//  reset    in   1       synchronous, active-low reset
//  start    in   1       request; sampled only in IDLE
//  op       in   1       0 = MULT (signed), 1 = DIV (signed)
//  a        in   DATA_W  rs operand (multiplicand / dividend), latched at start
//  b        in   DATA_W  rt operand (multiplier / divisor), latched at start
//  busy     out  1       high in any state other than IDLE
//  done     out  1       one-cycle completion pulse (DONE state)
//  div0     out  1       valid with done; 1 = DIV with b == 0
//  hi       out  DATA_W  HI register
//  lo       out  DATA_W  LO register
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; busy=0 done=0 div0=0 hi=0 lo=0; counter
//   and work registers cleared. Applies mid-operation: operation discarded.
//  FSM: IDLE -> MULT | DIV | DONE ; MULT -> DONE ; DIV -> FIX -> DONE ; DONE -> IDLE.
//  IDLE: start=1 latches a,b,op. op=0 -> MULT; op=1,b!=0 -> DIV; op=1,b==0 -> DONE
//   with div0=1, HI/LO unchanged.
//  MULT: radix-2 Booth on {P_hi, P_lo, q_-1} (2*DATA_W+1 bits), one step per cycle,
//   DATA_W cycles; arithmetic right shift. Entering DONE: hi=P[63:32] lo=P[31:0].
//  DIV: restoring divide on |a|, |b| (unsigned, DATA_W cycles, one quotient bit per
//   cycle). FIX: negate quotient if sign(a)^sign(b); negate remainder if sign(a).
//   Entering DONE: lo=quotient, hi=remainder (truncate toward zero).
//  Edge case a=0x80000000,b=0xFFFFFFFF: lo=0x80000000 hi=0, div0=0 (wraps, no trap).
//  Latency (start edge = edge 0): done high after edge 33 (MULT), edge 34 (DIV),
//   edge 1 (DIV by zero). done exactly one cycle; busy=1 in DONE, 0 after.
//  div0 updated only on entering DONE; holds until next DONE; 0 for MULT.
//  start while busy: ignored, no queueing. start in DONE cycle: ignored.
//  start held high: new op accepted on first IDLE cycle (back-to-back ok).
//  Operand changes after start edge have no effect.
//  HI/LO written only on entering DONE (never on div0, abort or reset-less idle).
// CONFIGURATION
//  MULTDIV_ABORT_EN defined: extra input port abort (1 bit, after b). abort=1 in
//   MULT/DIV/FIX -> IDLE at next edge, done not pulsed, HI/LO/div0 unchanged;
//   abort in IDLE/DONE ignored; start and abort together in IDLE: start wins.
//  Not defined: no abort port; every accepted operation runs to DONE.
// TESTING
//  MULT a=7 b=-3 -> done after edge 33, hi=0xFFFFFFFF lo=0xFFFFFFEB, div0=0.
//  MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0; busy high edges 1..33.
//  DIV a=-7 b=2 -> done after edge 34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  DIV a=5 b=0 -> done after edge 1, div0=1, hi/lo hold prior values (e.g. prior
//   MULT result); next MULT clears div0.
//  start pulsed at edge 10 mid-MULT -> ignored, result/latency of first op intact;
//   reset=0 at edge 15 -> busy=0 hi=lo=0 next cycle, no done pulse.
//  MULTDIV_ABORT_EN: DIV 100/7, abort at edge 20 -> IDLE at edge 21, no done, HI/LO
//   unchanged; following DIV 100/7 -> lo=14 hi=2.

Source files
------------

// File: rtl/mult_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_seq
// Description : Multicycle sequencer and iterative datapath for signed
//               MULT/DIV producing a HI/LO result pair.
//               MULT: radix-2 Booth, one step per cycle, DATA_W cycles.
//               DIV : restoring divide on magnitudes, then a sign fix-up cycle
//                     (quotient/remainder truncate toward zero).
// Ports       : clock  - system clock (posedge)
//               reset  - synchronous, active-low reset
//               start  - operation request, sampled only in IDLE
//               op     - 0 = MULT, 1 = DIV (both signed)
//               a, b   - rs / rt operands, latched on the accepting edge
//               abort  - (MULTDIV_ABORT_EN only) cancel a running operation
//               busy   - high in every state except IDLE
//               done   - one-cycle completion pulse
//               div0   - valid with done; DIV attempted with b == 0
//               hi, lo - HI/LO result registers
// Config      : `define MULTDIV_ABORT_EN adds the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
`ifdef MULTDIV_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // acc: Booth partial product high half / divider partial remainder.
  // One guard bit so Booth never overflows when subtracting -2^(W-1).
  logic [DATA_W:0]     acc_q, acc_d;
  // low: Booth multiplier/product low half / divider dividend->quotient.
  logic [DATA_W-1:0]   low_q, low_d;
  logic                qm1_q, qm1_d;
  // opnd: sign-extended multiplicand or zero-extended |divisor|.
  logic [DATA_W:0]     opnd_q, opnd_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                div0_q, div0_d;

  logic                abort_w;
  logic [DATA_W-1:0]   a_abs_w, b_abs_w;
  logic [DATA_W:0]     booth_sum_w;
  logic [DATA_W:0]     shifted_w, diff_w;

`ifdef MULTDIV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign a_abs_w = a[DATA_W-1] ? -a : a;
  assign b_abs_w = b[DATA_W-1] ? -b : b;

  always_comb begin
    booth_sum_w = acc_q;
    case ({low_q[0], qm1_q})
      2'b01:   booth_sum_w = acc_q + opnd_q;
      2'b10:   booth_sum_w = acc_q - opnd_q;
      default: booth_sum_w = acc_q;
    endcase
  end

  // Remainder magnitude is below the divisor, so shifted < 2^DATA_W and the
  // top bit of diff is a reliable borrow flag.
  assign shifted_w = {acc_q[DATA_W-1:0], low_q[DATA_W-1]};
  assign diff_w    = shifted_w - opnd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    low_d   = low_q;
    qm1_d   = qm1_q;
    opnd_d  = opnd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (!op) begin
            low_d   = b;
            opnd_d  = {a[DATA_W-1], a};
            state_d = S_MULT;
          end else if (b == '0) begin
            div0_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            low_d   = a_abs_w;
            opnd_d  = {1'b0, b_abs_w};
            negq_d  = a[DATA_W-1] ^ b[DATA_W-1];
            negr_d  = a[DATA_W-1];
            state_d = S_DIV;
          end
        end
      end

      S_MULT: begin
        // Arithmetic right shift of {acc, low, q-1} after the add/subtract.
        acc_d = {booth_sum_w[DATA_W], booth_sum_w[DATA_W:1]};
        low_d = {booth_sum_w[0], low_q[DATA_W-1:1]};
        qm1_d = low_q[0];
        cnt_d = cnt_q + 1'b1;
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_STEP) begin
          hi_d    = booth_sum_w[DATA_W:1];
          lo_d    = {booth_sum_w[0], low_q[DATA_W-1:1]};
          div0_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DIV: begin
        if (diff_w[DATA_W]) begin
          acc_d = shifted_w;
          low_d = {low_q[DATA_W-2:0], 1'b0};
        end else begin
          acc_d = diff_w;
          low_d = {low_q[DATA_W-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          lo_d    = negq_q ? -low_q : low_q;
          hi_d    = negr_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          div0_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      qm1_q   <= 1'b0;
      opnd_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      qm1_q   <= qm1_d;
      opnd_q  <= opnd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_seq
// Description : Directed, table-driven bench for mult_div_seq, plus
//               hand-written sequences for mid-operation start, reset,
//               back-to-back start and (when enabled) abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
`ifdef MULTDIV_ABORT_EN
  logic        abort;
`endif

  int n_cmp;
  int n_fail;

  mult_div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MULTDIV_ABORT_EN
    .abort (abort),
`endif
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive start after a rising edge (edge 0); the DUT samples it at edge 1.
  // Returns the number of edges until done is observed (bounded).
  task automatic run_op(input logic o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output logic busy1);
    @(posedge clock); #1;
    start = 1'b1; op = o; a = va; b = vb;
    lat = 0;
    busy1 = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) begin
        busy1 = busy;
        start = 1'b0;
        a = ~va;           // operand changes after acceptance must not matter
        b = va;
        op = ~o;
      end
    end
  endtask

  initial begin
    int   lat;
    logic b1;
    n_cmp  = 0;
    n_fail = 0;
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
`ifdef MULTDIV_ABORT_EN
    abort = 1'b0;
`endif

    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{1'b1, 32'd5,         32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1};
    vecs[4]  = '{1'b0, 32'h12345678,  32'd3,        32'h00000000, 32'h369D0368, 1'b0, 33};
    vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[6]  = '{1'b1, 32'd100,       32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 34};
    vecs[8]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, 34};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_div0", {31'd0, div0}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, b1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_edge1", i), {31'd0, b1}, 32'd1);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_div0", i), {31'd0, div0}, {31'd0, vecs[i].d0});
      @(posedge clock); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // start pulsed mid-MULT (edge 10) must be ignored
    begin
      int   n;
      logic seen;
      @(posedge clock); #1;
      start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFFFFFD;
      n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
        @(posedge clock); #1;
        n++;
        seen = done;
        if (n == 1) start = 1'b0;
        if (n == 9) begin start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0; end
        if (n == 10) start = 1'b0;
      end
      chk("midstart_latency", n, 33);
      chk("midstart_hi", hi, 32'hFFFFFFFF);
      chk("midstart_lo", lo, 32'hFFFFFFEB);
      chk("midstart_div0", {31'd0, div0}, 32'd0);
      @(posedge clock); #1;
    end

    // reset asserted at edge 15 of a MULT
    begin
      int   n;
      logic any_done;
      @(posedge clock); #1;
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
      any_done = 1'b0;
      for (n = 1; n <= 15; n++) begin
        @(posedge clock); #1;
        if (n == 1) start = 1'b0;
        if (n == 14) reset = 1'b0;
        any_done = any_done | done;
      end
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b1;
      repeat (40) begin
        @(posedge clock); #1;
        any_done = any_done | done;
      end
      chk("rst_no_done", {31'd0, any_done}, 32'd0);
    end

    // start held high: DIV by zero accepted again on first IDLE cycle
    begin
      logic [3:0] dseq;
      @(posedge clock); #1;
      start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clock); #1;
        dseq[k] = done;
      end
      start = 1'b0;
      chk("b2b_done_seq", {28'd0, dseq}, 32'h5);
      chk("b2b_div0", {31'd0, div0}, 32'd1);
      @(posedge clock); #1;
    end

`ifdef MULTDIV_ABORT_EN
    // abort of DIV 100/7 at edge 20, then a clean DIV 100/7
    begin
      logic any_done;
      run_op(1'b0, 32'd6, 32'd7, lat, b1);   // known HI/LO: 0 / 42
      @(posedge clock); #1;
      start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
      any_done = 1'b0;
      for (int n = 1; n <= 21; n++) begin
        @(posedge clock); #1;
        if (n == 1) start = 1'b0;
        if (n == 20) abort = 1'b1;
        if (n == 21) abort = 1'b0;
        any_done = any_done | done;
      end
      chk("abort_idle", {31'd0, busy}, 32'd0);
      chk("abort_no_done", {31'd0, any_done}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd42);
      run_op(1'b1, 32'd100, 32'd7, lat, b1);
      chk("abort_next_lat", lat, 34);
      chk("abort_next_lo", lo, 32'd14);
      chk("abort_next_hi", hi, 32'd2);
      @(posedge clock); #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
